// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one 8-bit channel among four
// byte producers, with a registered valid/ready output stage.
// Optional feature macro: ARB_LOCK_EN (adds i_lock port and a consecutive-grant
// counter bounded by LOCK_MAX). Default build has neither.
//
// state | meaning
// IDLE  | no byte pending, o_out_valid = 0
// BUSY  | byte pending on o_out, o_out_valid = 1

module mux4_rr_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_req,
  input  logic [7:0] i_input1,
  input  logic [7:0] i_input2,
  input  logic [7:0] i_input3,
  input  logic [7:0] i_input4,
`ifdef ARB_LOCK_EN
  input  logic [3:0] i_lock,
`endif
  output logic [3:0] o_grant,
  output logic [3:0] o_ack,
  output logic [1:0] o_selector,
  output logic [7:0] o_out,
  output logic       o_out_valid,
  input  logic       i_out_ready
);

  // LOCK_MAX must fit the 4-bit consecutive-grant counter
  if (LOCK_MAX < 1 || LOCK_MAX > 15) begin : g_bad_lock_max
    $error("LOCK_MAX out of range 1..15");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_ptr;
  logic [1:0] r_sel;
  logic [3:0] r_grant;
  logic [3:0] r_ack;
  logic [7:0] r_out;

  logic       w_hs;
  logic       w_arb;
  logic [3:0] w_mask_req;
  logic       w_found;
  logic [1:0] w_win;
  logic       w_grant_now;
  logic [7:0] w_data;
  logic       w_lock_hold;

`ifdef ARB_LOCK_EN
  logic [3:0] r_lock_cnt;
`endif

  // state register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // arbitration: scan from r_ptr+1 upward; the completing requester is masked
  // on a handshake so it cannot immediately win again (unless lock holds it)
  always_comb begin
    logic [1:0] v_idx;
    w_hs        = (r_state == ST_BUSY) && i_out_ready;
    w_arb       = ((r_state == ST_IDLE) && (i_req != 4'b0)) || w_hs;
    w_mask_req  = i_req;
    if (w_hs) w_mask_req[r_sel] = 1'b0;
    w_found     = 1'b0;
    w_win       = r_ptr;
    w_lock_hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      v_idx = r_ptr + 2'(k);
      if (!w_found && w_mask_req[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
`ifdef ARB_LOCK_EN
    w_lock_hold = w_hs && i_lock[r_sel] && i_req[r_sel] &&
                  (r_lock_cnt < 4'(LOCK_MAX - 1));
    if (w_lock_hold) begin
      w_found = 1'b1;
      w_win   = r_sel;
    end
`endif
    w_grant_now = w_arb && w_found;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_grant_now) w_state_nxt = ST_BUSY;
    else if (w_hs)   w_state_nxt = ST_IDLE;
  end

  // output decode
  always_comb begin
    o_out_valid = (r_state == ST_BUSY);
    o_grant     = r_grant;
    o_ack       = r_ack;
    o_selector  = r_sel;
    o_out       = r_out;
  end

  // 4x1 byte select for the winner
  always_comb begin
    case (w_win)
      2'd0:    w_data = i_input1;
      2'd1:    w_data = i_input2;
      2'd2:    w_data = i_input3;
      default: w_data = i_input4;
    endcase
  end

  // datapath: capture byte at grant time, pulse ack on handshake
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr   <= 2'd3;
      r_sel   <= 2'd0;
      r_grant <= 4'b0;
      r_ack   <= 4'b0;
      r_out   <= 8'h00;
    end else begin
      r_ack <= w_hs ? (4'b0001 << r_sel) : 4'b0;
      if (w_grant_now) begin
        r_out   <= w_data;
        r_sel   <= w_win;
        r_grant <= 4'b0001 << w_win;
        r_ptr   <= w_win;
      end else if (w_hs) begin
        r_grant <= 4'b0;
      end
    end
  end

`ifdef ARB_LOCK_EN
  // consecutive-grant counter: counts re-grants under lock, clears otherwise
  always_ff @(posedge i_clock) begin
    if (i_reset)          r_lock_cnt <= 4'd0;
    else if (w_grant_now) r_lock_cnt <= w_lock_hold ? r_lock_cnt + 4'd1 : 4'd0;
  end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios with constant
// expectations plus a randomized run against a behavioural reference model.

module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] in1, in2, in3, in4;
  logic [3:0] grant, ack;
  logic [1:0] sel;
  logic [7:0] dout;
  logic       valid;
  logic       ready;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit         m_busy;
  int         m_ptr;
  int         m_sel;
  logic [7:0] m_out;
  logic [3:0] m_grant;
  logic [3:0] m_ack;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.LOCK_MAX(4)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_req      (req),
    .i_input1   (in1),
    .i_input2   (in2),
    .i_input3   (in3),
    .i_input4   (in4),
`ifdef ARB_LOCK_EN
    .i_lock     (4'b0000),
`endif
    .o_grant    (grant),
    .o_ack      (ack),
    .o_selector (sel),
    .o_out      (dout),
    .o_out_valid(valid),
    .i_out_ready(ready)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // model of one clock edge, computed from the arbitration rules
  task automatic model_edge();
    logic [7:0] din [4];
    logic [3:0] cand;
    bit hs;
    int w;
    din[0] = in1; din[1] = in2; din[2] = in3; din[3] = in4;
    if (rst) begin
      m_busy = 0; m_ptr = 3; m_sel = 0; m_out = 8'h00; m_grant = 4'b0; m_ack = 4'b0;
    end else begin
      hs   = m_busy && ready;
      cand = req;
      if (hs) cand[m_sel] = 1'b0;
      m_ack = hs ? 4'(1 << m_sel) : 4'b0;
      if ((!m_busy || hs) && cand != 4'b0) begin
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          if (w < 0 && cand[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        m_busy = 1; m_out = din[w]; m_sel = w; m_grant = 4'(1 << w); m_ptr = w;
      end else if (hs) begin
        m_busy = 0; m_grant = 4'b0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({grant, ack, sel, dout, valid} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b ack=%b sel=%0d out=%h valid=%b, want all zero",
               grant, ack, sel, dout, valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; in1 = 8'hA5; ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({grant, sel, dout, valid, ack} !== {4'b0001, 2'd0, 8'hA5, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%b sel=%0d out=%h valid=%b ack=%b, want 0001 0 a5 1 0000",
               grant, sel, dout, valid, ack);
    end
    @(negedge clk);
    req = 4'b0000;
    n_tests++;
    if ({ack, valid, grant} !== {4'b0001, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_ack: got ack=%b valid=%b grant=%b, want 0001 0 0000", ack, valid, grant);
    end
    @(negedge clk);
    n_tests++;
    if ({ack, valid, dout, sel} !== {4'b0000, 1'b0, 8'hA5, 2'd0}) begin
      n_fail++;
      $display("FAIL single_idle_hold: got ack=%b valid=%b out=%h sel=%0d, want 0000 0 a5 0",
               ack, valid, dout, sel);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_out [5];
    exp_out[0] = 8'h11; exp_out[1] = 8'h22; exp_out[2] = 8'h33; exp_out[3] = 8'h44; exp_out[4] = 8'h11;
    do_reset();
    req = 4'b1111; ready = 1'b1;
    in1 = 8'h11; in2 = 8'h22; in3 = 8'h33; in4 = 8'h44;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (dout !== exp_out[k] || valid !== 1'b1 || grant !== 4'(1 << (k % 4))) begin
        n_fail++;
        $display("FAIL rotation_out[%0d]: got out=%h valid=%b grant=%b, want %h 1 %b",
                 k, dout, valid, grant, exp_out[k], 4'(1 << (k % 4)));
      end
      n_tests++;
      if (ack !== ((k == 0) ? 4'b0 : 4'(1 << ((k - 1) % 4)))) begin
        n_fail++;
        $display("FAIL rotation_ack[%0d]: got %b", k, ack);
      end
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0100; in3 = 8'h33; ready = 1'b0;
    @(negedge clk);
    in3 = 8'h99;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if ({dout, valid, ack, sel} !== {8'h33, 1'b1, 4'b0000, 2'd2}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got out=%h valid=%b ack=%b sel=%0d, want 33 1 0000 2",
                 k, dout, valid, ack, sel);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    req = 4'b0000;
    n_tests++;
    if ({ack, valid} !== {4'b0100, 1'b0}) begin
      n_fail++;
      $display("FAIL backpressure_ack: got ack=%b valid=%b, want 0100 0", ack, valid);
    end
    @(negedge clk);
    n_tests++;
    if (ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL backpressure_single_ack: got ack=%b, want 0000", ack);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010; in2 = 8'h22; ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dout, valid} !== {8'h22, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_pending: got out=%h valid=%b, want 22 1", dout, valid);
    end
    rst = 1'b1; ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b0000;
    n_tests++;
    if ({grant, ack, sel, dout, valid} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_mid_zero: got grant=%b ack=%b sel=%0d out=%h valid=%b, want all zero",
               grant, ack, sel, dout, valid);
    end
    req = 4'b1111; in1 = 8'h11;
    @(negedge clk);
    n_tests++;
    if ({ack, grant, dout} !== {4'b0000, 4'b0001, 8'h11}) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: got ack=%b grant=%b out=%h, want 0000 0001 11", ack, grant, dout);
    end
    req = 4'b0000; ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_lock();
    do_reset();
    req = 4'b0011; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (grant !== ((k % 2 == 0) ? 4'b0001 : 4'b0010)) begin
        n_fail++;
        $display("FAIL no_lock_alt[%0d]: got grant=%b, want %b", k, grant,
                 (k % 2 == 0) ? 4'b0001 : 4'b0010);
      end
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    rst = 1'b1;
    model_edge();
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 49) == 0);
      req   = 4'($urandom_range(0, 15));
      ready = ($urandom_range(0, 3) != 0);
      in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom); in4 = 8'($urandom);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      n_tests++;
      if ({grant, ack, sel, dout, valid} !== {m_grant, m_ack, 2'(m_sel), m_out, m_busy}) begin
        n_fail++;
        $display("FAIL random[%0d]: got grant=%b ack=%b sel=%0d out=%h valid=%b, want %b %b %0d %h %b",
                 n, grant, ack, sel, dout, valid, m_grant, m_ack, m_sel, m_out, m_busy);
      end
    end
    rst = 1'b0; req = 4'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; ready = 1'b0;
    in1 = 8'h00; in2 = 8'h00; in3 = 8'h00; in4 = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_reset_mid();
    test_no_lock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
